// File: rtl/knn_batch_scheduler.sv
// knn_batch_scheduler: runs one k-NN batch over the sorter array:
// clear, load test points, stream training set, drain, read labels.
module knn_batch_scheduler #(
  parameter int DATA_W    = 32,
  parameter int N_SOLVERS = 4,
  parameter int HW_K      = 10,
  parameter int TRAIN_AW  = 10,
  parameter int TEST_AW   = 8,
  parameter int PIPE_LAT  = 2,
  localparam int SEL_W  =
    (N_SOLVERS > 1) ? $clog2(N_SOLVERS) : 1,
  localparam int K_W    =
    (HW_K > 1) ? $clog2(HW_K) : 1,
  localparam int RES_AW =
    (N_SOLVERS * HW_K > 1) ?
    $clog2(N_SOLVERS * HW_K) : 1
) (
  input  logic                clk,
  input  logic                rst_int,
  input  logic                start,
  input  logic [SEL_W:0]      n_active,
  input  logic [TEST_AW-1:0]  test_base,
  input  logic [TRAIN_AW:0]   n_train,
  output logic [TEST_AW-1:0]  test_addr,
  input  logic [DATA_W-1:0]   test_rdata,
  output logic [TRAIN_AW-1:0] train_addr,
  input  logic [DATA_W-1:0]   train_rdata,
  output logic                sorter_clr,
  output logic [SEL_W-1:0]    solver_sel,
  output logic [DATA_W-1:0]   data_1,
  output logic                data_1_we,
  output logic [DATA_W-1:0]   data_2,
  output logic                knn_valid,
  output logic [K_W-1:0]      res_sel,
  input  logic [7:0]          res_data,
  output logic                res_wr,
  output logic [RES_AW-1:0]   res_addr,
  output logic [7:0]          res_wdata,
  output logic                busy,
  output logic                done
);

  localparam int PL_W = $clog2(PIPE_LAT + 1) + 1;
  localparam int CW0  =
    (TRAIN_AW + 1 > SEL_W + 1) ?
    TRAIN_AW + 1 : SEL_W + 1;
  localparam int CW   = (CW0 > PL_W) ? CW0 : PL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_READ,
    S_FIN
  } state_e;

  localparam state_e POST_STREAM =
    (PIPE_LAT > 0) ? S_DRAIN : S_READ;

  state_e state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      a_q, a_d;
  logic [CW-1:0]      t_q, t_d;
  logic [CW-1:0]      a_clamp;
  logic [TEST_AW-1:0] base_q, base_d;
  logic [K_W-1:0]     k_q, k_d;

  logic               ld_v_q, ld_v_d;
  logic               st_v_q, st_v_d;
  logic               rd_v_q, rd_v_d;
  logic [SEL_W-1:0]   ld_sel_q, ld_sel_d;
  logic [RES_AW-1:0]  ra_q, ra_d;
  logic [DATA_W-1:0]  d1_q, d2_q;
  logic [7:0]         rw_q;

  logic               ld_iss, st_iss, rd_iss;

  assign a_clamp =
    (CW'(n_active) > CW'(N_SOLVERS)) ?
    CW'(N_SOLVERS) : CW'(n_active);

  // Issue cycles; each stage's final cycle only
  // collects the last response.
  assign ld_iss = (state_q == S_LOAD) &&
                  (cnt_q != a_q);
  assign st_iss = (state_q == S_STREAM) &&
                  (cnt_q != t_q);
  assign rd_iss = (state_q == S_READ) &&
                  (cnt_q != a_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    t_d     = t_q;
    base_d  = base_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a_clamp;
          t_d    = CW'(n_train);
          base_d = test_base;
          cnt_d  = '0;
          k_d    = '0;
          state_d = (a_clamp == '0) ?
                    S_FIN : S_CLR;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (ld_iss) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = (t_q != '0) ?
                    S_STREAM : POST_STREAM;
        end
      end
      S_STREAM: begin
        if (st_iss) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = POST_STREAM;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(PIPE_LAT - 1)) begin
          cnt_d   = '0;
          k_d     = '0;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (!rd_iss) begin
          state_d = S_FIN;
        end else if (k_q == K_W'(HW_K - 1)) begin
          k_d   = '0;
          cnt_d = cnt_q + 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ld_v_d   = ld_iss;
    st_v_d   = st_iss;
    rd_v_d   = rd_iss;
    ld_sel_d = ld_iss ? SEL_W'(cnt_q) : ld_sel_q;
    ra_d     = ra_q;
    if (rd_iss) begin
      ra_d = RES_AW'(32'(cnt_q) * HW_K +
                     32'(k_q));
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      t_q      <= '0;
      base_q   <= '0;
      k_q      <= '0;
      ld_v_q   <= 1'b0;
      st_v_q   <= 1'b0;
      rd_v_q   <= 1'b0;
      ld_sel_q <= '0;
      ra_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      rw_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      t_q      <= t_d;
      base_q   <= base_d;
      k_q      <= k_d;
      ld_v_q   <= ld_v_d;
      st_v_q   <= st_v_d;
      rd_v_q   <= rd_v_d;
      ld_sel_q <= ld_sel_d;
      ra_q     <= ra_d;
      d1_q     <= data_1;
      d2_q     <= data_2;
      rw_q     <= res_wdata;
    end
  end

  // Memory responses pass straight through on the
  // strobe cycle and are held afterwards.
  assign data_1    = ld_v_q ? test_rdata  : d1_q;
  assign data_2    = st_v_q ? train_rdata : d2_q;
  assign res_wdata = rd_v_q ? res_data    : rw_q;

  assign data_1_we = ld_v_q;
  assign knn_valid = st_v_q;
  assign res_wr    = rd_v_q;
  assign res_addr  = ra_q;

  assign test_addr  = ld_iss ?
                      base_q + TEST_AW'(cnt_q) : '0;
  assign train_addr = st_iss ?
                      TRAIN_AW'(cnt_q) : '0;

  assign solver_sel = rd_iss ? SEL_W'(cnt_q) :
                      (ld_v_q ? ld_sel_q : '0);
  assign res_sel    = rd_iss ? k_q : '0;

  assign sorter_clr = (state_q == S_CLR);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);

endmodule

// File: doc/knn_batch_scheduler.md
Name: knn_batch_scheduler

Overview:
- Sequencer that runs one k-NN batch on the array of N_SOLVERS pipeline sorters without CPU involvement.
- Loads up to N_SOLVERS test points (one per solver) from a test-point memory and clears the sorters.
- Broadcasts every training point to all solvers, waits for the pipeline to drain, then copies each solver's HW_K nearest labels into a result memory.
- Sits between the KNN register file and the solver array, replacing per-point software writes of DATA_1/DATA_2/SOLVER_SEL.

Parameters:
- DATA_W, 32, point word width; {y[DATA_W-1:DATA_W/2], x[DATA_W/2-1:0]}
- N_SOLVERS, 4, number of parallel sorters
- HW_K, 10, neighbours kept per sorter
- TRAIN_AW, 10, training memory address width
- TEST_AW, 8, test memory address width
- PIPE_LAT, 2, sorter pipeline settle cycles after last valid
- Derived widths:
  - SEL_W = max(1, clog2(N_SOLVERS))
  - K_W = max(1, clog2(HW_K))
  - RES_AW = max(1, clog2(N_SOLVERS*HW_K))

Ports:
- clk  in  1  clock
- rst_int  in  1  reset, asynchronous, active-high
- start  in  1  begin batch; sampled only in IDLE
- n_active  in  SEL_W+1  test points in batch
- test_base  in  TEST_AW  first test-memory address
- n_train  in  TRAIN_AW+1  training points, 0..2^TRAIN_AW
- test_addr  out  TEST_AW  test memory read address
- test_rdata  in  DATA_W  test word, valid 1 cycle after address
- train_addr  out  TRAIN_AW  training memory read address
- train_rdata  in  DATA_W  training word, valid 1 cycle after address
- sorter_clr  out  1  one-cycle clear of all sorters
- solver_sel  out  SEL_W  target solver for load/readout
- data_1  out  DATA_W  test point to selected solver
- data_1_we  out  1  load strobe for data_1
- data_2  out  DATA_W  broadcast training point
- knn_valid  out  1  data_2 valid to all solvers
- res_sel  out  K_W  neighbour index for readout
- res_data  in  8  label from selected solver, valid 1 cycle after solver_sel/res_sel
- res_wr  out  1  result memory write strobe
- res_addr  out  RES_AW  result address = solver*HW_K + k
- res_wdata  out  8  label written
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - rst_int asynchronously forces state IDLE and all outputs/counters to 0.
  - Reset mid-batch aborts it: no done pulse, no further strobes.
- n_active handling:
  - Latched at start. Values > N_SOLVERS are clamped to N_SOLVERS (A).
  - A=0 → go straight to FIN.
- States, in order; each item stage takes N+1 cycles (N issue cycles plus one response cycle):
  - IDLE
    - busy=0.
    - start → CLR; busy=1 from the next cycle.
    - If A=0, start → FIN directly.
  - CLR
    - sorter_clr=1 for exactly one cycle.
  - LOAD, s=0..A-1
    - Issue test_addr = test_base+s; wraps modulo 2^TEST_AW.
    - Next cycle: data_1=test_rdata, solver_sel=s, data_1_we=1.
  - STREAM, i=0..n_train-1
    - Issue train_addr=i.
    - Next cycle: data_2=train_rdata, knn_valid=1.
    - n_train=0 → stage skipped entirely, no knn_valid.
    - train_addr never exceeds n_train-1; n_train=2^TRAIN_AW covers the full space without wrap.
  - DRAIN
    - Exactly PIPE_LAT cycles, all strobes low.
  - READ, s=0..A-1 outer, k=0..HW_K-1 inner
    - Drive solver_sel=s, res_sel=k.
    - Next cycle: res_wr=1, res_addr=s*HW_K+k, res_wdata=res_data.
  - FIN
    - done=1 for one cycle, busy=1 during FIN; then IDLE.
- Latency:
  - done asserts 1+(A+1)+(T+1 if T>0, else 0)+PIPE_LAT+(A*HW_K+1)+1 cycles after the start sample cycle.
  - A=0 → done asserts the cycle after start.
- Strobes:
  - data_1_we, knn_valid and res_wr are never asserted simultaneously.
  - data_1/data_2/res_wdata hold their last value when strobes are low.
- start while busy is ignored; inputs are latched only on accepted start.
- Each counter compares against its latched limit; no counter overflows its width.

Test Plan:
- Reset: assert rst_int during LOAD → all outputs 0 immediately; after release start=0 → busy stays 0, no strobes.
- Nominal (N_SOLVERS=4, HW_K=10, PIPE_LAT=2): start with n_active=4, test_base=8, n_train=3 →
  - sorter_clr once; data_1_we ×4, solver_sel 0..3, data_1 = words at addresses 8..11.
  - knn_valid ×3, data_2 = train words 0..2.
  - 40 res_wr, res_addr 0..39; done 54 cycles after start.
- n_train=0, n_active=2 → zero knn_valid, 20 res_wr (addr 0..19), done at cycle 1+3+0+2+21+1=28.
- n_active=0 → done one cycle after start, no other strobes. n_active=7 → clamped to 4 (40 res_wr).
- start pulsed during STREAM → ignored, single done. test_base=255, n_active=2 → test_addr 255 then 0.
- n_train=1024 (TRAIN_AW=10) → 1024 knn_valid, train_addr 0..1023 monotonic, no wrap.
